axi2mem_sram_bank: RTL and testbench



---
 rtl/axi2mem_sram_bank.sv | 206 ++++++++++++++++++++
 tb/tb_axi2mem_sram_bank.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi2mem_sram_bank.sv
// -----------------------------------------------------------------------------
// axi2mem_sram_bank
//
// Single-port, word-wide SRAM bank fed by the flattened axi2mem request stream.
// Reads go through a fixed-latency pipeline into a first-word-fall-through
// response FIFO. A credit counter stops read acceptance before the FIFO could
// overflow, so the consumer may stall responses without any data being lost.
//
// Handshakes: a transfer happens on the rising edge at which both valid and
// ready are 1. A producer holds valid and its payload until that edge. While
// resp_valid is 1 and resp_ready is 0, resp_rdata and resp_err stay unchanged.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous, active-high reset
//   req_valid   request present
//   req_ready   request accepted when req_valid && req_ready
//   req_we      1 = write, 0 = read
//   req_addr    byte address (low log2(DATA_WIDTH/8) bits ignored)
//   req_be      write byte enables
//   req_wdata   write data
//   resp_valid  read response available (FIFO head)
//   resp_ready  consumer takes the head when resp_valid && resp_ready
//   resp_rdata  read data (0 for out-of-range reads)
//   resp_err    read address was out of range
// -----------------------------------------------------------------------------
module axi2mem_sram_bank #(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 32,
  parameter int MEM_DEPTH       = 1024,
  parameter int READ_LATENCY    = 2,
  parameter int RESP_FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IDXW  = $clog2(MEM_DEPTH);
  localparam int CW    = $clog2(RESP_FIFO_DEPTH + 1);
  localparam int PW    = (RESP_FIFO_DEPTH > 1) ? $clog2(RESP_FIFO_DEPTH) : 1;

  localparam logic [CW-1:0] C_DEPTH = CW'(RESP_FIFO_DEPTH);
  localparam logic [PW-1:0] C_LAST  = PW'(RESP_FIFO_DEPTH - 1);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] w_word;
  logic                  w_in_range;
  logic [IDXW-1:0]       w_idx;

  assign w_word     = req_addr >> OFF;
  // Any word-index bit above the array index makes the access out of range;
  // this also keeps out-of-range writes from aliasing onto low words.
  assign w_in_range = ((w_word >> IDXW) == '0);
  assign w_idx      = w_word[IDXW-1:0];

  logic w_accept;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_pop;

  assign w_accept = req_valid && req_ready;
  assign w_wr_acc = w_accept && req_we;
  assign w_rd_acc = w_accept && !req_we;
  assign w_pop    = resp_valid && resp_ready;

  // ---------------------------------------------------------------------------
  // Storage array (contents survive reset)
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (w_wr_acc && w_in_range) begin
      for (int b = 0; b < BYTES; b++) begin
        if (req_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  // Array sampled at the accepting edge; a write accepted one cycle earlier is
  // already in the array, so read-after-write returns the new data.
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_rd_err;

  assign w_rd_data = w_in_range ? r_mem[w_idx] : '0;
  assign w_rd_err  = !w_in_range;

  // ---------------------------------------------------------------------------
  // Read pipeline: the FIFO storage is the last register rank, so the
  // pipeline holds READ_LATENCY-1 ranks and an empty FIFO shows the data
  // exactly READ_LATENCY cycles after the accept.
  // ---------------------------------------------------------------------------
  logic                  w_push_v;
  logic [DATA_WIDTH-1:0] w_push_d;
  logic                  w_push_e;

  if (READ_LATENCY == 1) begin : g_direct
    assign w_push_v = w_rd_acc;
    assign w_push_d = w_rd_data;
    assign w_push_e = w_rd_err;
  end else begin : g_pipe
    localparam int NS = READ_LATENCY - 1;

    logic                  r_pv [NS];
    logic [DATA_WIDTH-1:0] r_pd [NS];
    logic                  r_pe [NS];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < NS; s++) begin
          r_pv[s] <= 1'b0;
        end
      end else begin
        r_pv[0] <= w_rd_acc;
        for (int s = 1; s < NS; s++) begin
          r_pv[s] <= r_pv[s-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      r_pd[0] <= w_rd_data;
      r_pe[0] <= w_rd_err;
      for (int s = 1; s < NS; s++) begin
        r_pd[s] <= r_pd[s-1];
        r_pe[s] <= r_pe[s-1];
      end
    end

    assign w_push_v = r_pv[NS-1];
    assign w_push_d = r_pd[NS-1];
    assign w_push_e = r_pe[NS-1];
  end

  // ---------------------------------------------------------------------------
  // Response FIFO and credit counter
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_fd [RESP_FIFO_DEPTH];
  logic                  r_fe [RESP_FIFO_DEPTH];
  logic [PW-1:0]         r_wp;
  logic [PW-1:0]         r_rp;
  logic [CW-1:0]         r_cnt;
  // Reads in the pipeline plus FIFO occupancy; never exceeds RESP_FIFO_DEPTH,
  // so the FIFO cannot overflow.
  logic [CW-1:0]         r_outstanding;

  always_ff @(posedge clk) begin
    if (w_push_v) begin
      r_fd[r_wp] <= w_push_d;
      r_fe[r_wp] <= w_push_e;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp          <= '0;
      r_rp          <= '0;
      r_cnt         <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_push_v) begin
        r_wp <= (r_wp == C_LAST) ? '0 : r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= (r_rp == C_LAST) ? '0 : r_rp + 1'b1;
      end
      case ({w_push_v, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      case ({w_rd_acc, w_pop})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Everything is forced quiet while rst is high, including the
  // cycle in which rst first rises and the registers still hold old state.
  // ---------------------------------------------------------------------------
  assign resp_valid = !rst && (r_cnt != '0);
  assign resp_rdata = resp_valid ? r_fd[r_rp] : '0;
  assign resp_err   = resp_valid ? r_fe[r_rp] : 1'b0;
  // Writes never stall; reads stop once every FIFO slot is spoken for.
  // resp_ready is deliberately not consulted here.
  assign req_ready  = !rst && (req_we || (r_outstanding < C_DEPTH));

endmodule

// File: tb/tb_axi2mem_sram_bank.sv
// -----------------------------------------------------------------------------
// tb_axi2mem_sram_bank
//
// Directed bench for axi2mem_sram_bank with default parameters (512-bit words,
// 1024 words, read latency 2, 4-entry response FIFO). A table of single
// requests with hand-computed results is applied first, then hand-written
// sequences cover latency, read-after-write, backpressure, streaming and
// reset with reads in flight. Response payloads are checked in request order
// against an expected queue of {err, rdata}.
// -----------------------------------------------------------------------------
module tb_axi2mem_sram_bank;

  localparam int DW = 512;
  localparam int AW = 32;
  localparam int BW = DW / 8;

  localparam logic [BW-1:0] ALL_BE = {BW{1'b1}};
  localparam logic [DW-1:0] PA     = {64{8'hA5}};
  localparam logic [DW-1:0] P0     = {16{32'h0123_4567}};
  localparam logic [DW-1:0] P1     = {16{32'h89AB_CDEF}};
  localparam logic [DW-1:0] P2     = {16{32'hDEAD_BEEF}};
  localparam logic [DW-1:0] PX     = {16{32'h5555_AAAA}};
  localparam logic [DW-1:0] PFF    = {64{8'hFF}};
  localparam logic [DW-1:0] P11    = {64{8'h11}};
  localparam logic [DW-1:0] W1     = {8'h11, {63{8'hA5}}};

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [BW-1:0] req_be;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;

  always #5 clk = ~clk;

  axi2mem_sram_bank #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .MEM_DEPTH(1024),
    .READ_LATENCY(2),
    .RESP_FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_be(req_be),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [DW:0] exp_q[$];
  logic [DW:0] mon_e;

  task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Every response handshake is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got err=%0b rdata=%h want no response", resp_err, resp_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_payload", {resp_err, resp_rdata}, mon_e);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a posedge + 1 time step, return at the same point)
  // ---------------------------------------------------------------------------
  task automatic send(input logic we, input logic [AW-1:0] addr, input logic [BW-1:0] be,
                      input logic [DW-1:0] wd, input logic [DW:0] exp);
    int  c;
    logic done;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wd;
    done      = 1'b0;
    c         = 0;
    while (!done && c < 50) begin
      @(negedge clk);
      if (req_ready) begin
        done = 1'b1;
        if (!we) exp_q.push_back(exp);
      end
      @(posedge clk);
      #1;
      c++;
    end
    req_valid = 1'b0;
    if (!done) check("send_accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    int c;
    resp_ready = 1'b1;
    c = 0;
    while (exp_q.size() != 0 && c < 100) begin
      @(posedge clk);
      c++;
    end
    #1;
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[15];

  logic [AW-1:0] bp_addr[6];
  logic [DW:0]   bp_exp[6];

  initial begin
    int idx;
    logic [31:0] kw;

    vecs[0]  = '{1'b1, 32'h0000_0040, ALL_BE,     PA,  1'b0, '0};
    vecs[1]  = '{1'b0, 32'h0000_0040, '0,         '0,  1'b0, PA};
    vecs[2]  = '{1'b1, 32'h0000_0080, ALL_BE,     '0,  1'b0, '0};
    vecs[3]  = '{1'b1, 32'h0000_0080, BW'(1),     PFF, 1'b0, '0};
    vecs[4]  = '{1'b0, 32'h0000_0080, '0,         '0,  1'b0, DW'(8'hFF)};
    vecs[5]  = '{1'b1, 32'h0000_0000, ALL_BE,     P0,  1'b0, '0};
    vecs[6]  = '{1'b1, 32'h0001_0000, ALL_BE,     PFF, 1'b0, '0};
    vecs[7]  = '{1'b0, 32'h0001_0000, '0,         '0,  1'b1, '0};
    vecs[8]  = '{1'b0, 32'h0000_0000, '0,         '0,  1'b0, P0};
    vecs[9]  = '{1'b1, 32'h0000_FFC0, ALL_BE,     P1,  1'b0, '0};
    vecs[10] = '{1'b0, 32'h0000_FFC0, '0,         '0,  1'b0, P1};
    vecs[11] = '{1'b0, 32'h0001_0040, '0,         '0,  1'b1, '0};
    vecs[12] = '{1'b0, 32'h0000_0045, '0,         '0,  1'b0, PA};
    vecs[13] = '{1'b1, 32'h0000_0040, {1'b1, {(BW-1){1'b0}}}, P11, 1'b0, '0};
    vecs[14] = '{1'b0, 32'h0000_007F, '0,         '0,  1'b0, W1};

    bp_addr[0] = 32'h0000_0040;  bp_exp[0] = {1'b0, W1};
    bp_addr[1] = 32'h0000_0080;  bp_exp[1] = {1'b0, DW'(8'hFF)};
    bp_addr[2] = 32'h0000_0000;  bp_exp[2] = {1'b0, P0};
    bp_addr[3] = 32'h0000_FFC0;  bp_exp[3] = {1'b0, P1};
    bp_addr[4] = 32'h0001_0000;  bp_exp[4] = {1'b1, {DW{1'b0}}};
    bp_addr[5] = 32'h0000_0045;  bp_exp[5] = {1'b0, W1};

    // ---- reset -------------------------------------------------------------
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_be     = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready",   req_ready, 1'b0);
    check("rst_resp_valid",  resp_valid, 1'b0);
    check("rst_resp_rdata",  resp_rdata, '0);
    check("rst_resp_err",    resp_err, 1'b0);
    check("rst_outstanding", dut.r_outstanding, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("first_cycle_ready", req_ready, 1'b1);
    @(posedge clk);
    #1;

    // ---- table-driven vectors ---------------------------------------------
    for (int i = 0; i < 15; i++) begin
      send(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata,
           {vecs[i].exp_err, vecs[i].exp_rdata});
    end
    drain();

    // ---- read latency with an empty FIFO ------------------------------------
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0080;
    @(negedge clk);
    check("lat_accept", req_ready, 1'b1);
    exp_q.push_back({1'b0, DW'(8'hFF)});
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("lat_t_plus_1_idle", resp_valid, 1'b0);
    @(negedge clk);
    check("lat_t_plus_2_valid", resp_valid, 1'b1);
    @(posedge clk); #1;
    drain();

    // ---- read in the cycle right after a write to the same word ------------
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0200; req_be = ALL_BE; req_wdata = PX;
    @(negedge clk);
    check("raw_write_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    req_we = 1'b0;
    @(negedge clk);
    check("raw_read_ready", req_ready, 1'b1);
    exp_q.push_back({1'b0, PX});
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();

    // ---- backpressure: 6 reads with resp_ready low --------------------------
    resp_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      if (idx < 6) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = bp_addr[idx];
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      if (req_valid && req_ready) begin
        exp_q.push_back(bp_exp[idx]);
        idx++;
      end
      @(posedge clk); #1;
    end
    check("bp_accepted_count", idx, 4);
    @(negedge clk);
    check("bp_read_blocked", req_ready, 1'b0);
    check("bp_outstanding_full", dut.r_outstanding, 4);
    check("bp_head_valid", resp_valid, 1'b1);
    check("bp_head_hold", {resp_err, resp_rdata}, exp_q[0]);
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h0000_0300; req_be = ALL_BE; req_wdata = P2;
    @(negedge clk);
    check("bp_write_accepted", req_ready, 1'b1);
    check("bp_head_still_held", {resp_err, resp_rdata}, bp_exp[0]);
    @(posedge clk); #1;
    req_we = 1'b0;
    resp_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 6; c++) begin
      req_valid = 1'b1; req_addr = bp_addr[idx];
      @(negedge clk);
      if (req_ready) begin
        exp_q.push_back(bp_exp[idx]);
        idx++;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("bp_all_accepted", idx, 6);
    drain();

    // ---- streaming: 16 back-to-back reads -----------------------------------
    for (int k = 0; k < 16; k++) begin
      kw = 32'hC0DE_0000 + 32'(k);
      send(1'b1, 32'h0000_0400 + 32'(k * 64), ALL_BE, {16{kw}}, '0);
    end
    for (int k = 0; k < 16; k++) begin
      kw = 32'hC0DE_0000 + 32'(k);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0400 + 32'(k * 64);
      @(negedge clk);
      check("stream_ready", req_ready, 1'b1);
      if (req_ready) exp_q.push_back({1'b0, {16{kw}}});
      if (k == 1) check("stream_first_not_early", resp_valid, 1'b0);
      if (k == 2) check("stream_first_at_latency", resp_valid, 1'b1);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    drain();

    // ---- reset with three reads in flight ------------------------------------
    resp_ready = 1'b0;
    send(1'b0, 32'h0000_0040, '0, '0, {1'b0, W1});
    send(1'b0, 32'h0000_0080, '0, '0, {1'b0, DW'(8'hFF)});
    send(1'b0, 32'h0000_0000, '0, '0, {1'b0, P0});
    check("mid_outstanding_3", dut.r_outstanding, 3);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req_ready", req_ready, 1'b0);
    check("mid_rst_resp_valid", resp_valid, 1'b0);
    check("mid_rst_resp_rdata", resp_rdata, '0);
    check("mid_rst_resp_err", resp_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("post_rst_outstanding", dut.r_outstanding, 0);
    check("post_rst_req_ready", req_ready, 1'b1);
    check("post_rst_no_resp", resp_valid, 1'b0);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send(1'b0, 32'h0000_0300, '0, '0, {1'b0, P2});
    send(1'b0, 32'h0000_0040, '0, '0, {1'b0, W1});
    drain();

    // ---- report --------------------------------------------------------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
